eth_port_dispatch: RTL and testbench

- Sits directly downstream of the Ethernet receive FSM and consumes its 34-bit word stream (inWrEn, {eop, sop, data}).
- Buffers words in a FIFO and decodes the destination address in each packet's first word.
- Forwards the whole packet to port A or port B over a valid/ready interface; unknown-destination and malformed traffic is dropped and counted.

---
 rtl/eth_pkg.sv | 40 ++++
 rtl/eth_port_dispatch_fifo.sv | 58 +++++
 rtl/eth_port_dispatch.sv | 231 +++++++++++++++++++++++
 tb/tb_eth_port_dispatch.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet port dispatcher: word layout,
// default destination addresses and the writer/reader state encodings.
package eth_pkg;

   localparam int ETH_WORD_W = 34;
   localparam int SOP_BIT    = 32;
   localparam int EOP_BIT    = 33;

   localparam logic [31:0] DEFAULT_PORTA_ADDR = 32'hABCD;
   localparam logic [31:0] DEFAULT_PORTB_ADDR = 32'hBEEF;

   typedef enum logic [1:0] {
      WR_IDLE    = 2'd0,
      WR_PKT     = 2'd1,
      WR_DISCARD = 2'd2
   } wrState_t;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_FWD_A = 2'd1,
      RD_FWD_B = 2'd2,
      RD_DROP  = 2'd3
   } rdState_t;

   // Snapshot of both FSMs, brought out so checkers can bind to it.
   typedef struct packed {
      wrState_t wrState;
      rdState_t rdState;
      logic     firstWord;
   } dbgState_t;

   function automatic logic isSop(input logic [ETH_WORD_W-1:0] word);
      return word[SOP_BIT];
   endfunction

   function automatic logic isEop(input logic [ETH_WORD_W-1:0] word);
      return word[EOP_BIT];
   endfunction

endpackage

// File: rtl/eth_port_dispatch_fifo.sv
// Word FIFO between the writer and reader FSMs. The head word is visible
// combinationally; a write into a full FIFO is ignored (no write-through).
module eth_word_fifo
   import eth_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    wrEn,
   input  logic [ETH_WORD_W-1:0]   wrData,
   input  logic                    rdEn,
   output logic [ETH_WORD_W-1:0]   head,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [ETH_WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]         wrPtr;
   logic [AW-1:0]         rdPtr;
   logic                  doWr;
   logic                  doRd;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign doWr  = wrEn && !full;
   assign doRd  = rdEn && !empty;
   assign head  = mem[rdPtr];

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (doWr) begin
         mem[wrPtr] <= wrData;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doWr) wrPtr <= wrPtr + 1'b1;
         if (doRd) rdPtr <= rdPtr + 1'b1;
         case ({doWr, doRd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/eth_port_dispatch.sv
// Ethernet port dispatcher: buffers the receive word stream, decodes the
// destination in each header word and forwards packets to port A or B.
// Unknown destinations, stray words and overflowed tails are dropped.
//
// Handshake: on each port a word transfers on a cycle where portXValid and
// portXReady are both high; valid never depends on ready, and data is zero
// whenever valid is low. Only one port is ever valid at a time.
module eth_port_dispatch
   import eth_pkg::*;
#(
   parameter logic [31:0] PORTA_ADDR = DEFAULT_PORTA_ADDR,
   parameter logic [31:0] PORTB_ADDR = DEFAULT_PORTB_ADDR,
   parameter int          DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    inWrEn,
   input  logic [ETH_WORD_W-1:0]   inData,
   output logic                    portAValid,
   output logic [ETH_WORD_W-1:0]   portAData,
   input  logic                    portAReady,
   output logic                    portAAbort,
   output logic                    portBValid,
   output logic [ETH_WORD_W-1:0]   portBData,
   input  logic                    portBReady,
   output logic                    portBAbort,
   output logic [15:0]             dropCnt,
   output logic [15:0]             pktCntA,
   output logic [15:0]             pktCntB,
   output dbgState_t               dbgState,
   output logic [$clog2(DEPTH):0]  dbgFifoCount
);

   wrState_t              wrState;
   wrState_t              wrNext;
   rdState_t              rdState;
   rdState_t              rdNext;
   logic                  firstWord;
   logic                  firstWordNext;
   logic                  fifoWrEn;
   logic                  fifoRdEn;
   logic                  fifoEmpty;
   logic                  fifoFull;
   logic [ETH_WORD_W-1:0] head;
   logic                  inSop;
   logic                  inEop;
   logic                  headSop;
   logic                  headEop;
   logic                  hitA;
   logic                  hitB;
   logic                  truncated;
   logic                  wrDrop;
   logic                  rdDrop;
   logic                  pktDoneA;
   logic                  pktDoneB;
   logic [16:0]           dropSum;

   eth_word_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk    (clk),
      .resetN (resetN),
      .wrEn   (fifoWrEn),
      .wrData (inData),
      .rdEn   (fifoRdEn),
      .head   (head),
      .empty  (fifoEmpty),
      .full   (fifoFull),
      .count  (dbgFifoCount)
   );

   assign inSop     = isSop(inData);
   assign inEop     = isEop(inData);
   assign headSop   = isSop(head);
   assign headEop   = isEop(head);
   assign hitA      = (head[31:0] == PORTA_ADDR);
   assign hitB      = (head[31:0] == PORTB_ADDR);
   // A sop at the head after the current packet started means the old
   // packet lost its tail; the sop belongs to the next packet.
   assign truncated = headSop && !firstWord;
   assign dbgState  = '{wrState: wrState, rdState: rdState, firstWord: firstWord};

   // FSM state registers for writer and reader.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wrState   <= WR_IDLE;
         rdState   <= RD_IDLE;
         firstWord <= 1'b0;
      end else begin
         wrState   <= wrNext;
         rdState   <= rdNext;
         firstWord <= firstWordNext;
      end
   end

   // Writer: admit whole packets while space lasts, discard the rest.
   always_comb begin
      wrNext   = wrState;
      fifoWrEn = 1'b0;
      wrDrop   = 1'b0;
      if (inWrEn) begin
         case (wrState)
            WR_IDLE: begin
               if (!inSop) begin
                  wrDrop = 1'b1;
               end else if (!fifoFull) begin
                  fifoWrEn = 1'b1;
                  if (!inEop) wrNext = WR_PKT;
               end else begin
                  wrDrop = 1'b1;
                  if (!inEop) wrNext = WR_DISCARD;
               end
            end
            WR_PKT: begin
               if (!fifoFull) begin
                  fifoWrEn = 1'b1;
                  if (inEop) wrNext = WR_IDLE;
               end else begin
                  wrDrop = 1'b1;
                  wrNext = inEop ? WR_IDLE : WR_DISCARD;
               end
            end
            WR_DISCARD: begin
               wrDrop = 1'b1;
               if (inEop) wrNext = WR_IDLE;
            end
            default: wrNext = WR_IDLE;
         endcase
      end
   end

   // Reader: decode the header, then stream or drop the packet.
   always_comb begin
      rdNext        = rdState;
      firstWordNext = firstWord;
      fifoRdEn      = 1'b0;
      rdDrop        = 1'b0;
      pktDoneA      = 1'b0;
      pktDoneB      = 1'b0;
      portAValid    = 1'b0;
      portAData     = '0;
      portAAbort    = 1'b0;
      portBValid    = 1'b0;
      portBData     = '0;
      portBAbort    = 1'b0;
      case (rdState)
         RD_IDLE: begin
            if (!fifoEmpty) begin
               if (!headSop) begin
                  fifoRdEn = 1'b1;
                  rdDrop   = 1'b1;
               end else if (hitA) begin
                  rdNext        = RD_FWD_A;
                  firstWordNext = 1'b1;
               end else if (hitB) begin
                  rdNext        = RD_FWD_B;
                  firstWordNext = 1'b1;
               end else begin
                  rdNext        = RD_DROP;
                  firstWordNext = 1'b1;
               end
            end
         end
         RD_FWD_A: begin
            if (!fifoEmpty) begin
               if (truncated) begin
                  portAAbort = 1'b1;
                  rdNext     = RD_IDLE;
               end else begin
                  portAValid = 1'b1;
                  portAData  = head;
                  if (portAReady) begin
                     fifoRdEn      = 1'b1;
                     firstWordNext = 1'b0;
                     if (headEop) begin
                        pktDoneA = 1'b1;
                        rdNext   = RD_IDLE;
                     end
                  end
               end
            end
         end
         RD_FWD_B: begin
            if (!fifoEmpty) begin
               if (truncated) begin
                  portBAbort = 1'b1;
                  rdNext     = RD_IDLE;
               end else begin
                  portBValid = 1'b1;
                  portBData  = head;
                  if (portBReady) begin
                     fifoRdEn      = 1'b1;
                     firstWordNext = 1'b0;
                     if (headEop) begin
                        pktDoneB = 1'b1;
                        rdNext   = RD_IDLE;
                     end
                  end
               end
            end
         end
         RD_DROP: begin
            if (!fifoEmpty) begin
               if (truncated) begin
                  rdNext = RD_IDLE;
               end else begin
                  fifoRdEn      = 1'b1;
                  rdDrop        = 1'b1;
                  firstWordNext = 1'b0;
                  if (headEop) rdNext = RD_IDLE;
               end
            end
         end
         default: rdNext = RD_IDLE;
      endcase
   end

   assign dropSum = {1'b0, dropCnt} + 17'(wrDrop) + 17'(rdDrop);

   // Drop counter saturates; packet counters wrap.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         dropCnt <= '0;
         pktCntA <= '0;
         pktCntB <= '0;
      end else begin
         dropCnt <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
         if (pktDoneA) pktCntA <= pktCntA + 16'd1;
         if (pktDoneB) pktCntB <= pktCntB + 16'd1;
      end
   end

endmodule

// File: tb/tb_eth_port_dispatch.sv
// Self-checking bench for eth_port_dispatch. A packet-level model predicts
// which words each port must deliver and how many words must be dropped.
module tb_eth_port_dispatch;
   import eth_pkg::*;

   localparam int          DEPTH  = 16;
   localparam logic [31:0] ADDR_A = 32'hABCD;
   localparam logic [31:0] ADDR_B = 32'hBEEF;

   logic              clk = 1'b0;
   logic              resetN;
   logic              inWrEn;
   logic [33:0]       inData;
   logic              portAValid, portAReady, portAAbort;
   logic              portBValid, portBReady, portBAbort;
   logic [33:0]       portAData, portBData;
   logic [15:0]       dropCnt, pktCntA, pktCntB;
   dbgState_t         dbgState;
   logic [4:0]        dbgFifoCount;

   int vectors = 0;
   int miscompares = 0;
   logic [33:0] expA[$];
   logic [33:0] expB[$];
   logic [33:0] gotA[$];
   logic [33:0] gotB[$];
   int expDrop = 0, expPktA = 0, expPktB = 0;
   int abortA = 0, abortB = 0, bothValid = 0, idleDataBad = 0;
   int readyModeA = 0, readyModeB = 0;  // 0 high, 1 random, 2 toggle, 3 low

   eth_port_dispatch #(.PORTA_ADDR(ADDR_A), .PORTB_ADDR(ADDR_B), .DEPTH(DEPTH)) dut (
      .clk(clk), .resetN(resetN), .inWrEn(inWrEn), .inData(inData),
      .portAValid(portAValid), .portAData(portAData), .portAReady(portAReady), .portAAbort(portAAbort),
      .portBValid(portBValid), .portBData(portBData), .portBReady(portBReady), .portBAbort(portBAbort),
      .dropCnt(dropCnt), .pktCntA(pktCntA), .pktCntB(pktCntB),
      .dbgState(dbgState), .dbgFifoCount(dbgFifoCount)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- ready drivers ----------------
   function automatic logic next_ready(input int mode, input logic cur);
      case (mode)
         0:       return 1'b1;
         1:       return 1'($urandom_range(0, 1));
         2:       return ~cur;
         default: return 1'b0;
      endcase
   endfunction

   initial begin
      portAReady = 1'b0;
      portBReady = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         portAReady = next_ready(readyModeA, portAReady);
         portBReady = next_ready(readyModeB, portBReady);
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (resetN) begin
         if (portAValid && portAReady) gotA.push_back(portAData);
         if (portBValid && portBReady) gotB.push_back(portBData);
         if (portAAbort) abortA++;
         if (portBAbort) abortB++;
         if (portAValid && portBValid) bothValid++;
         if ((!portAValid && portAData !== '0) || (!portBValid && portBData !== '0)) idleDataBad++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_word(input logic eop, input logic sop, input logic [31:0] d);
      inWrEn = 1'b1;
      inData = {eop, sop, d};
      @(posedge clk);
      #1;
      inWrEn = 1'b0;
      inData = '0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Builds a well-formed packet, records the model's expectation, drives it.
   task automatic send_packet(input logic [31:0] hdr, input int len);
      logic [33:0] words[$];
      words = {};
      for (int i = 0; i < len; i++)
         words.push_back({1'(i == len - 1), 1'(i == 0), (i == 0) ? hdr : 32'($urandom)});
      if (hdr == ADDR_A) begin
         foreach (words[i]) expA.push_back(words[i]);
         expPktA++;
      end else if (hdr == ADDR_B) begin
         foreach (words[i]) expB.push_back(words[i]);
         expPktB++;
      end else begin
         expDrop += len;
      end
      foreach (words[i]) drive_word(words[i][33], words[i][32], words[i][31:0]);
   endtask

   function automatic logic [31:0] random_header();
      case ($urandom_range(0, 4))
         0, 1:    return ADDR_A;
         2:       return ADDR_B;
         3:       return 32'h0001_ABCD;  // matches A only in the low 16 bits
         default: return {16'h5A5A, 16'($urandom)};
      endcase
   endfunction

   task automatic clear_scoreboard();
      expA = {};
      expB = {};
      gotA = {};
      gotB = {};
      abortA = 0;
      abortB = 0;
      bothValid = 0;
      idleDataBad = 0;
   endtask

   // Waits (bounded) until every predicted word has arrived, then lets
   // any dropped tails finish draining.
   task automatic drain(input int budget);
      int n = 0;
      while ((gotA.size() < expA.size() || gotB.size() < expB.size()) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      vectors++;
      if (n >= budget) begin
         miscompares++;
         $display("FAIL drain_timeout got A=%0d B=%0d words, required A=%0d B=%0d",
                  gotA.size(), gotB.size(), expA.size(), expB.size());
      end
      idle_cycles(24);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetN = 1'b0;
      inWrEn = 1'b0;
      inData = '0;
      idle_cycles(3);
      vectors++;
      if ({portAValid, portBValid, portAAbort, portBAbort} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_valid got %b required 0000", {portAValid, portBValid, portAAbort, portBAbort});
      end
      vectors++;
      if (portAData !== '0 || portBData !== '0) begin
         miscompares++;
         $display("FAIL reset_data got A=%h B=%h required 0", portAData, portBData);
      end
      vectors++;
      if (dropCnt !== 16'd0 || pktCntA !== 16'd0 || pktCntB !== 16'd0 || dbgFifoCount !== 5'd0) begin
         miscompares++;
         $display("FAIL reset_counters got drop=%0d a=%0d b=%0d fifo=%0d required 0",
                  dropCnt, pktCntA, pktCntB, dbgFifoCount);
      end
      resetN = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_port_a();
      logic [31:0] w1, w2, w3;
      clear_scoreboard();
      readyModeA = 0;
      readyModeB = 3;
      idle_cycles(2);
      w1 = $urandom;
      w2 = $urandom;
      w3 = $urandom;
      drive_word(1'b0, 1'b1, ADDR_A);
      vectors++;
      if (portAValid !== 1'b0) begin
         miscompares++;
         $display("FAIL porta_decode_cycle valid got %b required 0", portAValid);
      end
      drive_word(1'b0, 1'b0, w1);
      vectors++;
      if (portAValid !== 1'b1 || portAData !== {2'b01, ADDR_A}) begin
         miscompares++;
         $display("FAIL porta_latency got valid=%b data=%h required valid=1 data=%h",
                  portAValid, portAData, {2'b01, ADDR_A});
      end
      drive_word(1'b0, 1'b0, w2);
      drive_word(1'b1, 1'b0, w3);
      expA = '{{2'b01, ADDR_A}, {2'b00, w1}, {2'b00, w2}, {2'b10, w3}};
      expPktA++;
      drain(200);
      vectors++;
      if (gotA.size() != expA.size() || gotB.size() != 0) begin
         miscompares++;
         $display("FAIL porta_count got A=%0d B=%0d required A=%0d B=0", gotA.size(), gotB.size(), expA.size());
      end
      foreach (expA[i]) if (i < gotA.size()) begin
         vectors++;
         if (gotA[i] !== expA[i]) begin
            miscompares++;
            $display("FAIL porta_word[%0d] got %h required %h", i, gotA[i], expA[i]);
         end
      end
      vectors++;
      if (pktCntA !== 16'(expPktA) || pktCntB !== 16'(expPktB)) begin
         miscompares++;
         $display("FAIL porta_pktcnt got a=%0d b=%0d required a=%0d b=%0d", pktCntA, pktCntB, expPktA, expPktB);
      end
   endtask

   task automatic test_port_b_toggle();
      clear_scoreboard();
      readyModeA = 0;
      readyModeB = 2;
      idle_cycles(2);
      send_packet(ADDR_B, 6);
      drain(200);
      vectors++;
      if (gotB.size() != expB.size() || gotA.size() != 0) begin
         miscompares++;
         $display("FAIL portb_count got A=%0d B=%0d required A=0 B=%0d", gotA.size(), gotB.size(), expB.size());
      end
      foreach (expB[i]) if (i < gotB.size()) begin
         vectors++;
         if (gotB[i] !== expB[i]) begin
            miscompares++;
            $display("FAIL portb_word[%0d] got %h required %h", i, gotB[i], expB[i]);
         end
      end
      vectors++;
      if (pktCntB !== 16'(expPktB)) begin
         miscompares++;
         $display("FAIL portb_pktcnt got %0d required %0d", pktCntB, expPktB);
      end
   endtask

   task automatic test_unknown_drop();
      clear_scoreboard();
      readyModeA = 0;
      readyModeB = 0;
      send_packet(32'h1234, 3);
      drain(200);
      vectors++;
      if (dropCnt !== 16'(expDrop) || gotA.size() != 0 || gotB.size() != 0) begin
         miscompares++;
         $display("FAIL unknown_drop got drop=%0d A=%0d B=%0d required drop=%0d A=0 B=0",
                  dropCnt, gotA.size(), gotB.size(), expDrop);
      end
   endtask

   task automatic test_overflow_abort();
      logic [33:0] words[$];
      clear_scoreboard();
      readyModeA = 3;
      readyModeB = 0;
      idle_cycles(2);
      words = {};
      for (int i = 0; i < 20; i++)
         words.push_back({1'(i == 19), 1'(i == 0), (i == 0) ? ADDR_A : 32'($urandom)});
      foreach (words[i]) drive_word(words[i][33], words[i][32], words[i][31:0]);
      for (int i = 0; i < DEPTH; i++) expA.push_back(words[i]);
      expDrop += 20 - DEPTH;
      idle_cycles(2);
      vectors++;
      if (dropCnt !== 16'(expDrop) || dbgFifoCount !== 5'(DEPTH)) begin
         miscompares++;
         $display("FAIL overflow_drop got drop=%0d fifo=%0d required drop=%0d fifo=%0d",
                  dropCnt, dbgFifoCount, expDrop, DEPTH);
      end
      readyModeA = 0;
      drain(200);
      send_packet(ADDR_B, 4);
      drain(200);
      vectors++;
      if (gotA.size() != expA.size() || gotB.size() != expB.size()) begin
         miscompares++;
         $display("FAIL overflow_count got A=%0d B=%0d required A=%0d B=%0d",
                  gotA.size(), gotB.size(), expA.size(), expB.size());
      end
      foreach (expA[i]) if (i < gotA.size()) begin
         vectors++;
         if (gotA[i] !== expA[i]) begin
            miscompares++;
            $display("FAIL overflow_a_word[%0d] got %h required %h", i, gotA[i], expA[i]);
         end
      end
      foreach (expB[i]) if (i < gotB.size()) begin
         vectors++;
         if (gotB[i] !== expB[i]) begin
            miscompares++;
            $display("FAIL overflow_b_word[%0d] got %h required %h", i, gotB[i], expB[i]);
         end
      end
      vectors++;
      if (abortA != 1 || abortB != 0) begin
         miscompares++;
         $display("FAIL overflow_abort got a=%0d b=%0d required a=1 b=0", abortA, abortB);
      end
      vectors++;
      if (pktCntA !== 16'(expPktA) || pktCntB !== 16'(expPktB) || dropCnt !== 16'(expDrop)) begin
         miscompares++;
         $display("FAIL overflow_counters got a=%0d b=%0d drop=%0d required a=%0d b=%0d drop=%0d",
                  pktCntA, pktCntB, dropCnt, expPktA, expPktB, expDrop);
      end
   endtask

   task automatic test_stray_single();
      clear_scoreboard();
      readyModeA = 0;
      readyModeB = 0;
      drive_word(1'b0, 1'b0, $urandom);
      expDrop++;
      idle_cycles(1);
      send_packet(ADDR_A, 1);
      drain(200);
      vectors++;
      if (gotA.size() != 1 || (gotA.size() == 1 && gotA[0] !== {2'b11, ADDR_A})) begin
         miscompares++;
         $display("FAIL stray_single got %0d words first=%h required 1 word %h",
                  gotA.size(), (gotA.size() > 0) ? gotA[0] : 34'h0, {2'b11, ADDR_A});
      end
      vectors++;
      if (dropCnt !== 16'(expDrop) || pktCntA !== 16'(expPktA)) begin
         miscompares++;
         $display("FAIL stray_counters got drop=%0d a=%0d required drop=%0d a=%0d",
                  dropCnt, pktCntA, expDrop, expPktA);
      end
   endtask

   task automatic test_random();
      clear_scoreboard();
      for (int p = 0; p < 14; p++) begin
         readyModeA = $urandom_range(0, 2);
         readyModeB = $urandom_range(0, 2);
         if ($urandom_range(0, 3) == 0) begin
            drive_word(1'($urandom_range(0, 1)), 1'b0, $urandom);
            expDrop++;
         end
         send_packet(random_header(), $urandom_range(1, 8));
         drain(400);
      end
      vectors++;
      if (gotA.size() != expA.size() || gotB.size() != expB.size()) begin
         miscompares++;
         $display("FAIL random_count got A=%0d B=%0d required A=%0d B=%0d",
                  gotA.size(), gotB.size(), expA.size(), expB.size());
      end
      foreach (expA[i]) if (i < gotA.size()) begin
         vectors++;
         if (gotA[i] !== expA[i]) begin
            miscompares++;
            $display("FAIL random_a_word[%0d] got %h required %h", i, gotA[i], expA[i]);
         end
      end
      foreach (expB[i]) if (i < gotB.size()) begin
         vectors++;
         if (gotB[i] !== expB[i]) begin
            miscompares++;
            $display("FAIL random_b_word[%0d] got %h required %h", i, gotB[i], expB[i]);
         end
      end
      vectors++;
      if (dropCnt !== 16'(expDrop) || pktCntA !== 16'(expPktA) || pktCntB !== 16'(expPktB)) begin
         miscompares++;
         $display("FAIL random_counters got drop=%0d a=%0d b=%0d required drop=%0d a=%0d b=%0d",
                  dropCnt, pktCntA, pktCntB, expDrop, expPktA, expPktB);
      end
      vectors++;
      if (abortA != 0 || abortB != 0 || bothValid != 0 || idleDataBad != 0) begin
         miscompares++;
         $display("FAIL random_protocol got abortA=%0d abortB=%0d both=%0d idleData=%0d required all 0",
                  abortA, abortB, bothValid, idleDataBad);
      end
   endtask

   task automatic test_back_to_back();
      clear_scoreboard();
      readyModeA = 0;
      readyModeB = 0;
      idle_cycles(2);
      for (int p = 0; p < 16; p++) begin
         send_packet(random_header(), $urandom_range(1, 6));
         idle_cycles(1);
      end
      drain(400);
      vectors++;
      if (gotA.size() != expA.size() || gotB.size() != expB.size()) begin
         miscompares++;
         $display("FAIL b2b_count got A=%0d B=%0d required A=%0d B=%0d",
                  gotA.size(), gotB.size(), expA.size(), expB.size());
      end
      foreach (expA[i]) if (i < gotA.size()) begin
         vectors++;
         if (gotA[i] !== expA[i]) begin
            miscompares++;
            $display("FAIL b2b_a_word[%0d] got %h required %h", i, gotA[i], expA[i]);
         end
      end
      foreach (expB[i]) if (i < gotB.size()) begin
         vectors++;
         if (gotB[i] !== expB[i]) begin
            miscompares++;
            $display("FAIL b2b_b_word[%0d] got %h required %h", i, gotB[i], expB[i]);
         end
      end
      vectors++;
      if (dropCnt !== 16'(expDrop) || pktCntA !== 16'(expPktA) || pktCntB !== 16'(expPktB)) begin
         miscompares++;
         $display("FAIL b2b_counters got drop=%0d a=%0d b=%0d required drop=%0d a=%0d b=%0d",
                  dropCnt, pktCntA, pktCntB, expDrop, expPktA, expPktB);
      end
      vectors++;
      if (abortA != 0 || abortB != 0 || bothValid != 0 || idleDataBad != 0) begin
         miscompares++;
         $display("FAIL b2b_protocol got abortA=%0d abortB=%0d both=%0d idleData=%0d required all 0",
                  abortA, abortB, bothValid, idleDataBad);
      end
   endtask

   task automatic test_async_reset();
      clear_scoreboard();
      readyModeA = 3;
      readyModeB = 0;
      idle_cycles(2);
      drive_word(1'b0, 1'b1, ADDR_A);
      drive_word(1'b0, 1'b0, $urandom);
      drive_word(1'b0, 1'b0, $urandom);
      vectors++;
      if (portAValid !== 1'b1) begin
         miscompares++;
         $display("FAIL areset_midpkt valid got %b required 1", portAValid);
      end
      #3;
      resetN = 1'b0;
      #1;
      vectors++;
      if (portAValid !== 1'b0 || portAData !== '0 || pktCntA !== 16'd0 || pktCntB !== 16'd0
          || dropCnt !== 16'd0 || dbgFifoCount !== 5'd0) begin
         miscompares++;
         $display("FAIL areset_clear got valid=%b data=%h a=%0d b=%0d drop=%0d fifo=%0d required all 0",
                  portAValid, portAData, pktCntA, pktCntB, dropCnt, dbgFifoCount);
      end
      idle_cycles(2);
      resetN = 1'b1;
      expDrop = 0;
      expPktA = 0;
      expPktB = 0;
      clear_scoreboard();
      readyModeA = 0;
      idle_cycles(2);
      send_packet(ADDR_A, 3);
      send_packet(ADDR_B, 2);
      drain(200);
      vectors++;
      if (gotA.size() != expA.size() || gotB.size() != expB.size()) begin
         miscompares++;
         $display("FAIL areset_count got A=%0d B=%0d required A=%0d B=%0d",
                  gotA.size(), gotB.size(), expA.size(), expB.size());
      end
      foreach (expA[i]) if (i < gotA.size()) begin
         vectors++;
         if (gotA[i] !== expA[i]) begin
            miscompares++;
            $display("FAIL areset_a_word[%0d] got %h required %h", i, gotA[i], expA[i]);
         end
      end
      foreach (expB[i]) if (i < gotB.size()) begin
         vectors++;
         if (gotB[i] !== expB[i]) begin
            miscompares++;
            $display("FAIL areset_b_word[%0d] got %h required %h", i, gotB[i], expB[i]);
         end
      end
      vectors++;
      if (pktCntA !== 16'd1 || pktCntB !== 16'd1 || dropCnt !== 16'd0) begin
         miscompares++;
         $display("FAIL areset_counters got a=%0d b=%0d drop=%0d required a=1 b=1 drop=0",
                  pktCntA, pktCntB, dropCnt);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_port_a();
      test_port_b_toggle();
      test_unknown_drop();
      test_overflow_abort();
      test_stray_single();
      test_random();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
